// File: rtl/dispatch_pkg.sv
// Shared encodings for the dispatch controller: RS one-hot targets, FSM states, ROB tag width.
// No logic, no latency, no flow control.
package dispatch_pkg;

  localparam int ROB_TAG_W = 6;

  localparam logic [3:0] RS_ALU    = 4'b1000;
  localparam logic [3:0] RS_BRANCH = 4'b0100;
  localparam logic [3:0] RS_LSU    = 4'b0010;
  localparam logic [3:0] RS_FPU    = 4'b0001;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_ILLEGAL = 2'd2
  } state_t;

  function automatic logic is_rs_dest_valid(input logic [3:0] dest);
    return (dest == RS_ALU) || (dest == RS_BRANCH) || (dest == RS_LSU) || (dest == RS_FPU);
  endfunction

endpackage

// File: rtl/rob_tag_alloc.sv
// ROB tail pointer and occupancy tracker; tail is the tag handed to the next dispatched op.
// Updates one cycle after fire/commit; full blocks further allocation.
module rob_tag_alloc import dispatch_pkg::*; #(
  parameter  int ROB_DEPTH = 64,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic             commit,
  input  logic             flush,
  output logic [TAG_W-1:0] tail,
  output logic             full
);

  logic [TAG_W:0] rob_count;
  logic           commit_eff;

  // A retire reported against an empty ROB carries no entry to release.
  assign commit_eff = commit && (rob_count != '0);
  assign full       = (rob_count == (TAG_W+1)'(ROB_DEPTH));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tail      <= '0;
      rob_count <= '0;
    end else begin
      if (fire) begin
        tail <= tail + TAG_W'(1);
      end
      if (fire && !commit_eff) begin
        rob_count <= rob_count + (TAG_W+1)'(1);
      end else if (!fire && commit_eff) begin
        rob_count <= rob_count - (TAG_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch stage: holds one fetched op, fires it to its RS and allocates a ROB tag.
// Accept in N, earliest fire in N+1; fe_ready drops while the held op is blocked. DISPATCH_PERF_EN adds stall counters.
module dispatch_ctrl import dispatch_pkg::*; #(
  parameter  int ROB_DEPTH = 64,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fe_valid,
  output logic             fe_ready,
  input  logic [31:0]      fe_pc,
  input  logic [31:0]      fe_inst,
  output logic [31:0]      dc_pc,
  output logic [31:0]      dc_inst,
  input  logic [3:0]       dc_rs_dest,
  input  logic [3:0]       rs_free,
  output logic [3:0]       rs_we,
  output logic             rob_we,
  output logic [TAG_W-1:0] dest_rob,
  input  logic             commit_valid,
  input  logic             flush,
  output logic             illegal,
  output logic [31:0]      perf_rob_stall,
  output logic [31:0]      perf_rs_stall
);

  state_t state;
  logic   rob_full;
  logic   dest_ok;
  logic   rs_avail;
  logic   fire;
  logic   accept;

  assign dest_ok  = is_rs_dest_valid(dc_rs_dest);
  assign rs_avail = |(dc_rs_dest & rs_free);
  assign fire     = (state == ST_HOLD) && dest_ok && rs_avail && !rob_full && !flush && !reset;
  assign fe_ready = (state == ST_EMPTY) || fire;
  assign accept   = fe_valid && fe_ready && !flush;

  assign rs_we  = fire ? dc_rs_dest : 4'b0000;
  assign rob_we = fire;

  rob_tag_alloc #(.ROB_DEPTH(ROB_DEPTH)) u_rob_tag_alloc (
    .clk    (clk),
    .reset  (reset),
    .fire   (fire),
    .commit (commit_valid),
    .flush  (flush),
    .tail   (dest_rob),
    .full   (rob_full)
  );

  // Accept wins over fire so a firing slot refills in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      dc_pc   <= '0;
      dc_inst <= '0;
      illegal <= 1'b0;
    end else if (flush) begin
      state   <= ST_EMPTY;
      illegal <= 1'b0;
    end else if (accept) begin
      state   <= ST_HOLD;
      dc_pc   <= fe_pc;
      dc_inst <= fe_inst;
    end else if (fire) begin
      state <= ST_EMPTY;
    end else if ((state == ST_HOLD) && !dest_ok) begin
      state   <= ST_ILLEGAL;
      illegal <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] rob_stall_q;
  logic [31:0] rs_stall_q;

  // ROB-full takes precedence so each blocked cycle is charged to one cause only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rob_stall_q <= '0;
      rs_stall_q  <= '0;
    end else if (state == ST_HOLD) begin
      if (rob_full) begin
        if (rob_stall_q != '1) rob_stall_q <= rob_stall_q + 32'd1;
      end else if (dest_ok && !rs_avail) begin
        if (rs_stall_q != '1) rs_stall_q <= rs_stall_q + 32'd1;
      end
    end
  end

  assign perf_rob_stall = rob_stall_q;
  assign perf_rs_stall  = rs_stall_q;
`else
  assign perf_rob_stall = '0;
  assign perf_rs_stall  = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against a queue-based ROB model.
module tb_dispatch_ctrl;

  localparam int DEPTH = 64;

`ifdef DISPATCH_PERF_EN
  localparam logic [31:0] RS_STALL_EXP = 32'd5;
`else
  localparam logic [31:0] RS_STALL_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_valid;
  logic        fe_ready;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic [31:0] dc_pc;
  logic [31:0] dc_inst;
  logic [3:0]  dc_rs_dest;
  logic [3:0]  rs_free;
  logic [3:0]  rs_we;
  logic        rob_we;
  logic [5:0]  dest_rob;
  logic        commit_valid;
  logic        flush;
  logic        illegal;
  logic [31:0] perf_rob_stall;
  logic [31:0] perf_rs_stall;

  always #5 clk = ~clk;

  dispatch_ctrl #(.ROB_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .fe_valid       (fe_valid),
    .fe_ready       (fe_ready),
    .fe_pc          (fe_pc),
    .fe_inst        (fe_inst),
    .dc_pc          (dc_pc),
    .dc_inst        (dc_inst),
    .dc_rs_dest     (dc_rs_dest),
    .rs_free        (rs_free),
    .rs_we          (rs_we),
    .rob_we         (rob_we),
    .dest_rob       (dest_rob),
    .commit_valid   (commit_valid),
    .flush          (flush),
    .illegal        (illegal),
    .perf_rob_stall (perf_rob_stall),
    .perf_rs_stall  (perf_rs_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an occupied slot, a trap flag, and the ROB as a queue of live tags.
  bit          m_held;
  bit          m_trap;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  int          rob_q[$];
  int          m_tail;
  logic [31:0] m_rob_stall;
  logic [31:0] m_rs_stall;

  logic [3:0]  obs_rs_we;
  logic        obs_rob_we;
  logic [5:0]  obs_dest;
  logic        obs_ready;
  logic        obs_illegal;
  logic [31:0] obs_dc_pc;
  logic [31:0] obs_rs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called with inputs already driven just after a rising edge; checks mid-cycle, then advances.
  task automatic step();
    bit hold, onehot, room, fire, ready, accept;
    #2;
    hold   = m_held && !m_trap;
    onehot = ($countones(dc_rs_dest) == 1);
    room   = (rob_q.size() < DEPTH);
    fire   = hold && onehot && ((dc_rs_dest & rs_free) != 4'b0) && room && !flush && !reset;
    ready  = (!m_held && !m_trap) || fire;
    accept = fe_valid && ready && !flush;

    obs_rs_we    = rs_we;
    obs_rob_we   = rob_we;
    obs_dest     = dest_rob;
    obs_ready    = fe_ready;
    obs_illegal  = illegal;
    obs_dc_pc    = dc_pc;
    obs_rs_stall = perf_rs_stall;

    if (reset) begin
      chk("reset_rs_we", rs_we, 0);
      chk("reset_rob_we", rob_we, 0);
    end else begin
      chk("fe_ready", fe_ready, ready);
      chk("rs_we", rs_we, fire ? dc_rs_dest : 4'b0);
      chk("rob_we", rob_we, fire);
      chk("dest_rob", dest_rob, m_tail);
      chk("illegal", illegal, m_trap);
      chk("dc_pc", dc_pc, m_pc);
      chk("dc_inst", dc_inst, m_inst);
      chk("perf_rob_stall", perf_rob_stall, m_rob_stall);
      chk("perf_rs_stall", perf_rs_stall, m_rs_stall);
    end

    if (reset) begin
      m_held = 0; m_trap = 0; m_pc = '0; m_inst = '0;
      rob_q.delete(); m_tail = 0; m_rob_stall = '0; m_rs_stall = '0;
    end else begin
`ifdef DISPATCH_PERF_EN
      if (hold && !room) m_rob_stall++;
      else if (hold && onehot && ((dc_rs_dest & rs_free) == 4'b0)) m_rs_stall++;
`endif
      if (flush) begin
        m_held = 0; m_trap = 0; rob_q.delete(); m_tail = 0;
      end else begin
        if (commit_valid && rob_q.size() > 0) void'(rob_q.pop_front());
        if (fire) begin
          rob_q.push_back(m_tail);
          m_tail = (m_tail + 1) % DEPTH;
        end
        if (accept) begin
          m_held = 1; m_pc = fe_pc; m_inst = fe_inst;
        end else if (fire) begin
          m_held = 0;
        end else if (hold && !onehot) begin
          m_trap = 1; m_held = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; fe_valid = 0; fe_pc = '0; fe_inst = '0; dc_rs_dest = '0;
    rs_free = '0; commit_valid = 0; flush = 0;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    // Reset, then two back-to-back ALU ops.
    do_reset();
    fe_valid = 1; fe_pc = 32'h0000_0100; fe_inst = 32'h0050_0093;
    dc_rs_dest = 4'b1000; rs_free = 4'b1111;
    step();
    chk("reset_ready", obs_ready, 1);
    chk("reset_dc_pc", obs_dc_pc, 0);
    chk("accept_no_fire", obs_rob_we, 0);
    fe_pc = 32'h0000_0104; fe_inst = 32'h00a0_0113;
    step();
    chk("first_rs_we", obs_rs_we, 4'b1000);
    chk("first_rob_we", obs_rob_we, 1);
    chk("first_tag", obs_dest, 0);
    fe_pc = 32'h0000_0108;
    step();
    chk("second_tag", obs_dest, 1);

    // Fill the ROB, observe the block, release one entry, see the tag wrap.
    for (int i = 0; i < 62; i++) begin
      fe_pc = 32'h0000_010c + 32'(4 * i);
      step();
    end
    step();
    chk("full_rob_we", obs_rob_we, 0);
    chk("full_ready", obs_ready, 0);
    commit_valid = 1;
    step();
    chk("commit_cycle_rob_we", obs_rob_we, 0);
    commit_valid = 0; fe_valid = 0;
    step();
    chk("wrap_rob_we", obs_rob_we, 1);
    chk("wrap_tag", obs_dest, 0);

    // Target RS busy for five cycles.
    do_reset();
    fe_valid = 1; fe_pc = 32'h0000_2000; fe_inst = 32'h0000_2003;
    dc_rs_dest = 4'b0010; rs_free = 4'b1101;
    step();
    fe_valid = 0;
    repeat (5) begin
      step();
      chk("rs_busy_rs_we", obs_rs_we, 0);
    end
    rs_free = 4'b1111;
    step();
    chk("rs_freed_rs_we", obs_rs_we, 4'b0010);
    chk("perf_rs_stall_5", obs_rs_stall, RS_STALL_EXP);

    // Three fires, then an unsupported op traps until flush, which also clears the tail.
    do_reset();
    fe_valid = 1; dc_rs_dest = 4'b1000; rs_free = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fe_pc = 32'h0000_3000 + 32'(4 * i);
      step();
    end
    dc_rs_dest = 4'b0000;
    step();
    repeat (4) begin
      step();
      chk("illegal_held", obs_illegal, 1);
      chk("illegal_ready", obs_ready, 0);
    end
    flush = 1;
    step();
    flush = 0; dc_rs_dest = 4'b1000;
    step();
    chk("post_flush_illegal", obs_illegal, 0);
    chk("post_flush_ready", obs_ready, 1);
    chk("post_flush_tag", obs_dest, 0);

    // Fire and commit together at occupancy 10, confirmed by how many fires reach full.
    do_reset();
    fe_valid = 1; dc_rs_dest = 4'b0100; rs_free = 4'b1111; fe_pc = 32'h0000_4000;
    repeat (11) step();
    commit_valid = 1;
    step();
    chk("fire_with_commit", obs_rob_we, 1);
    commit_valid = 0;
    repeat (54) step();
    step();
    chk("full_after_54", obs_rob_we, 0);
    commit_valid = 1; fe_valid = 0;
    step();
    commit_valid = 0;
    flush = 1; fe_valid = 1; fe_pc = 32'hdead_0000;
    step();
    chk("flush_rob_we", obs_rob_we, 0);
    chk("flush_rs_we", obs_rs_we, 0);
    flush = 0; fe_valid = 0;
    step();
    chk("flush_no_capture", obs_dc_pc == 32'hdead_0000, 0);

    // Randomized traffic, commit pressure varied per block so the ROB sometimes fills.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int cprob;
      cprob = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 90);
      for (int i = 0; i < 200; i++) begin
        int r;
        r = $urandom_range(0, 99);
        fe_valid     = ($urandom_range(0, 99) < 70);
        fe_pc        = $urandom;
        fe_inst      = $urandom;
        dc_rs_dest   = (r < 3) ? 4'($urandom_range(0, 15)) : (4'b0001 << $urandom_range(0, 3));
        rs_free      = 4'($urandom);
        commit_valid = ($urandom_range(0, 99) < cprob);
        flush        = ($urandom_range(0, 199) == 0);
        reset        = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    reset = 0; flush = 0; commit_valid = 0; fe_valid = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 64, number of ROB entries; power of two; tag width = log2(ROB_DEPTH) = 6.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fe_valid  in  1  fetched instruction present.
REQ-005 fe_ready  out  1  controller accepts fetched instruction this cycle.
REQ-006 fe_pc, fe_inst  in  32 each  fetched PC and instruction word.
REQ-007 dc_pc, dc_inst  out  32 each  held PC/instruction driven to decoder.
REQ-008 dc_rs_dest  in  4  decoder one-hot target RS: 1000 ALU, 0100 branch, 0010 LSU, 0001 FPU, 0000 unsupported.
REQ-009 rs_free  in  4  per-RS free-slot flag, same bit order.
REQ-010 rs_we  out  4  one-hot RS write strobe.
REQ-011 rob_we  out  1  ROB allocate strobe.
REQ-012 dest_rob  out  6  ROB tag for held instruction (= tail pointer).
REQ-013 commit_valid  in  1  ROB retired one entry.
REQ-014 flush  in  1  pipeline flush/misprediction.
REQ-015 illegal  out  1  held instruction unsupported.
REQ-016 perf_rob_stall, perf_rs_stall  out  32 each  stall-cycle counters.

Function
REQ-017 States: EMPTY, HOLD, ILLEGAL; single holding register (dc_pc, dc_inst).
REQ-018 fe_ready = (state==EMPTY) or fire; fe_ready=0 in ILLEGAL.
REQ-019 Accept = fe_valid & fe_ready & !flush; loads holding register, next state HOLD.
REQ-020 fire = HOLD & dc_rs_dest one-hot & |(dc_rs_dest & rs_free) & rob_count<ROB_DEPTH & !flush.
REQ-021 On fire: rs_we=dc_rs_dest, rob_we=1, dest_rob=tail; tail<=tail+1 mod ROB_DEPTH; next state HOLD if accept same cycle, else EMPTY.
REQ-022 rs_we=0, rob_we=0 in every cycle without fire.
REQ-023 Minimum latency: accept in cycle N, earliest fire in N+1; back-to-back fire every cycle when resources free.
REQ-024 rob_count: +1 on fire, -1 on commit_valid, unchanged when both; commit_valid with rob_count==0 ignored.
REQ-025 Full: rob_count==ROB_DEPTH blocks fire; tail wraps 63->0.
REQ-026 HOLD with dc_rs_dest==0000 or non-one-hot: next state ILLEGAL, illegal=1 held until flush or reset; no strobes.
REQ-027 flush highest priority: next state EMPTY, tail<=0, rob_count<=0, no fire, no accept, commit ignored that cycle.

Reset
REQ-028 On reset: state EMPTY, tail 0, rob_count 0, dc_pc 0, dc_inst 0, illegal 0, rs_we 0, rob_we 0, perf counters 0, fe_ready 1 first cycle after reset.
REQ-029 Reset mid-operation discards held instruction; no strobe in the reset cycle.

Configuration
REQ-030 Macro DISPATCH_PERF_EN: defined -> perf_rob_stall increments (saturating at 2^32-1) each HOLD cycle blocked by rob_count==ROB_DEPTH; perf_rs_stall increments each HOLD cycle with ROB space but target RS not free; counters unaffected by flush.
REQ-031 Without DISPATCH_PERF_EN: both perf outputs tied to 0, no counter flops.

Structure
REQ-032 Package dispatch_pkg: RS one-hot constants (RS_ALU, RS_BRANCH, RS_LSU, RS_FPU), state enum, ROB_TAG_W.
REQ-033 Sub-module rob_tag_alloc: tail pointer and rob_count with fire/commit/flush inputs, full output.

Verification
REQ-034 Reset, fe_valid=1 OP_IMM, dc_rs_dest=1000, rs_free=1111 -> cycle 2 rs_we=1000, rob_we=1, dest_rob=0; next instruction dest_rob=1.
REQ-035 64 fires, no commits -> rob_count=64, fire blocked, fe_ready=0; one commit_valid -> next cycle fire with dest_rob=0 (wrap).
REQ-036 HOLD, dc_rs_dest=0010, rs_free=1101 for 5 cycles -> no strobes, perf_rs_stall=5 (PERF_EN); rs_free=1111 -> rs_we=0010.
REQ-037 dc_rs_dest=0000 -> illegal=1, fe_ready=0 indefinitely; flush -> illegal=0, EMPTY, tail=0.
REQ-038 fire and commit_valid same cycle at rob_count=10 -> rob_count stays 10; flush with fe_valid=1 and resources free -> no rs_we/rob_we, instruction not captured.
